// File: rtl/gt_bringup_pkg.sv
// Shared state encoding, default timing constants and helpers for the
// GT quad bring-up controller and its frequency meters.
package gt_bringup_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RESET    = 4'd1,
        ST_WAIT_PLL = 4'd2,
        ST_WAIT_TX  = 4'd3,
        ST_WAIT_RX  = 4'd4,
        ST_MEAS     = 4'd5,
        ST_QUAL     = 4'd6,
        ST_UP       = 4'd7,
        ST_FAIL     = 4'd8
    } gt_state_e;

    // Default timing, all in apb3clk cycles (200 MHz)
    localparam int unsigned RST_CYC_DEF     = 12;
    localparam int unsigned TIMEOUT_CYC_DEF = 300000;
    localparam int unsigned WIN_CYC_DEF     = 4096;
    localparam int unsigned FREQ_MIN_DEF    = 204;
    localparam int unsigned FREQ_MAX_DEF    = 208;
    localparam int unsigned STABLE_CYC_DEF  = 2048;
    localparam int unsigned MAX_RETRY_DEF   = 3;

    // Widths of the reported counters
    localparam int unsigned FREQ_CNT_W  = 12;
    localparam int unsigned RETRY_CNT_W = 2;
    localparam int unsigned DROP_CNT_W  = 8;

    // Flops in an input synchronizer: two for metastability, plus one more
    // when the synchronized signal also feeds a rising-edge detector.
    function automatic int unsigned sync2(input bit edge_detect);
        return edge_detect ? 32'd3 : 32'd2;
    endfunction

endpackage

// File: rtl/gt_freq_meter.sv
// Counts rising edges of an asynchronous divided user clock over a fixed
// window. A one-cycle start pulse opens the window; done pulses for one
// cycle when the (saturating) count has been latched into count_o.
module gt_freq_meter
    import gt_bringup_pkg::*;
#(
    parameter int unsigned WIN_CYC = WIN_CYC_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  div16_i,
    input  logic                  start_i,
    output logic                  done_o,
    output logic [FREQ_CNT_W-1:0] count_o
);

    localparam int unsigned SYNC_N = sync2(1'b1);
    localparam int unsigned WIN_W  = $clog2(WIN_CYC);
    localparam logic [WIN_W-1:0]      WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [FREQ_CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_N-1:0]     sync_q;
    logic                  rise;
    logic                  busy_q, busy_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [FREQ_CNT_W-1:0] acc_q, acc_d;
    logic [FREQ_CNT_W-1:0] res_q, res_d;
    logic                  done_q, done_d;

    // Three-flop synchronizer; the extra stage gives the previous sample
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], div16_i};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

    // Window sequencing and saturating accumulation
    always_comb begin
        busy_d = busy_q;
        win_d  = win_q;
        acc_d  = acc_q;
        res_d  = res_q;
        done_d = 1'b0;
        if (start_i) begin
            busy_d = 1'b1;
            win_d  = '0;
            acc_d  = '0;
        end else if (busy_q) begin
            if (rise && (acc_q != CNT_MAX)) begin
                acc_d = acc_q + 1'b1;
            end
            if (win_q == WIN_LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                res_d  = acc_d;
            end else begin
                win_d = win_q + 1'b1;
            end
        end
    end

    // Window state and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            win_q  <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            win_q  <= win_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            done_q <= done_d;
        end
    end

    assign done_o  = done_q;
    assign count_o = res_q;

endmodule

// File: rtl/gt_link_bringup_ctrl.sv
// GT quad bring-up sequencer: pulses the wrapper reset, waits for PLL lock
// and TX/RX reset-done, checks user-clock frequencies, qualifies link
// status, then monitors the link. Failures retry the whole sequence a
// bounded number of times before parking in FAIL.
module gt_link_bringup_ctrl
    import gt_bringup_pkg::*;
#(
    parameter int unsigned RST_CYC     = RST_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned WIN_CYC     = WIN_CYC_DEF,
    parameter int unsigned FREQ_MIN    = FREQ_MIN_DEF,
    parameter int unsigned FREQ_MAX    = FREQ_MAX_DEF,
    parameter int unsigned STABLE_CYC  = STABLE_CYC_DEF,
    parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic        apb3clk,
    input  logic        apb3presetn,
    input  logic        enable,
    input  logic        lcpll_lock,
    input  logic        tx_resetdone,
    input  logic        rx_resetdone,
    input  logic        link_status,
    input  logic        txusrclk_div16,
    input  logic        rxusrclk_div16,
    output logic        gt_reset,
    output logic        link_stable,
    output logic        fail,
    output logic [3:0]  state,
    output logic [11:0] tx_freq_cnt,
    output logic [11:0] rx_freq_cnt,
    output logic [1:0]  retry_cnt,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned SYNC_N = sync2(1'b0);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC);
    localparam int unsigned STAB_W = $clog2(STABLE_CYC);

    localparam logic [TMR_W-1:0]       RST_LAST   = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0]       TMO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [STAB_W-1:0]      STAB_LAST  = STAB_W'(STABLE_CYC - 1);
    localparam logic [FREQ_CNT_W-1:0]  FREQ_LO    = FREQ_CNT_W'(FREQ_MIN);
    localparam logic [FREQ_CNT_W-1:0]  FREQ_HI    = FREQ_CNT_W'(FREQ_MAX);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LAST = RETRY_CNT_W'(MAX_RETRY);
    localparam logic [DROP_CNT_W-1:0]  DROP_MAX   = '1;

    // Level inputs from the wrapper, index order: lock, txdone, rxdone, link
    logic [3:0] async_in;
    logic [3:0] sync_out;
    logic       lock_s, txdone_s, rxdone_s, link_s;

    gt_state_e              state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic [RETRY_CNT_W-1:0] retry_q, retry_d;
    logic [DROP_CNT_W-1:0]  drop_q, drop_d;
    logic                   gt_reset_q, link_stable_q, fail_q;
    logic                   fail_evt;
    logic                   meas_start;
    logic                   tx_done, rx_done;
    logic [FREQ_CNT_W-1:0]  tx_cnt, rx_cnt;

    assign async_in = {link_status, rx_resetdone, tx_resetdone, lcpll_lock};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        logic [SYNC_N-1:0] ff_q;

        // Two-flop synchronizer for one wrapper status input
        always_ff @(posedge apb3clk or negedge apb3presetn) begin
            if (!apb3presetn) begin
                ff_q <= '0;
            end else begin
                ff_q <= {ff_q[SYNC_N-2:0], async_in[gi]};
            end
        end

        assign sync_out[gi] = ff_q[SYNC_N-1];
    end

    assign lock_s   = sync_out[0];
    assign txdone_s = sync_out[1];
    assign rxdone_s = sync_out[2];
    assign link_s   = sync_out[3];

    // Both meters are started together, so their windows stay aligned
    assign meas_start = (state_d == ST_MEAS) && (state_q != ST_MEAS);

    gt_freq_meter #(
        .WIN_CYC (WIN_CYC)
    ) u_tx_meter (
        .clk_i   (apb3clk),
        .rst_ni  (apb3presetn),
        .div16_i (txusrclk_div16),
        .start_i (meas_start),
        .done_o  (tx_done),
        .count_o (tx_cnt)
    );

    gt_freq_meter #(
        .WIN_CYC (WIN_CYC)
    ) u_rx_meter (
        .clk_i   (apb3clk),
        .rst_ni  (apb3presetn),
        .div16_i (rxusrclk_div16),
        .start_i (meas_start),
        .done_o  (rx_done),
        .count_o (rx_cnt)
    );

    function automatic logic freq_ok(input logic [FREQ_CNT_W-1:0] cnt);
        return (cnt >= FREQ_LO) && (cnt <= FREQ_HI);
    endfunction

    // Next-state, retry/drop bookkeeping and link-qualification counter
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        drop_d   = drop_q;
        stab_d   = '0;
        fail_evt = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RESET;
                    retry_d = '0;
                end
            end
            ST_RESET: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_WAIT_PLL;
                end
            end
            ST_WAIT_PLL: begin
                if (lock_s) begin
                    state_d = ST_WAIT_TX;
                end else if (tmr_q == TMO_LAST) begin
                    fail_evt = 1'b1;
                end
            end
            ST_WAIT_TX: begin
                if (txdone_s) begin
                    state_d = ST_WAIT_RX;
                end else if (tmr_q == TMO_LAST) begin
                    fail_evt = 1'b1;
                end
            end
            ST_WAIT_RX: begin
                if (rxdone_s) begin
                    state_d = ST_MEAS;
                end else if (tmr_q == TMO_LAST) begin
                    fail_evt = 1'b1;
                end
            end
            ST_MEAS: begin
                if (tx_done && rx_done) begin
                    if (freq_ok(tx_cnt) && freq_ok(rx_cnt)) begin
                        state_d = ST_QUAL;
                    end else begin
                        fail_evt = 1'b1;
                    end
                end
            end
            ST_QUAL: begin
                // Qualifying wins over a timeout landing on the same cycle
                if (link_s && (stab_q == STAB_LAST)) begin
                    state_d = ST_UP;
                end else if (tmr_q == TMO_LAST) begin
                    fail_evt = 1'b1;
                end else if (link_s) begin
                    stab_d = stab_q + 1'b1;
                end
            end
            ST_UP: begin
                // A link drop is counted even when lock loss takes priority
                if (!link_s && (drop_q != DROP_MAX)) begin
                    drop_d = drop_q + 1'b1;
                end
                if (!lock_s) begin
                    fail_evt = 1'b1;
                end else if (!link_s) begin
                    state_d = ST_QUAL;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fail_evt) begin
            if (retry_q < RETRY_LAST) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_RESET;
            end else begin
                state_d = ST_FAIL;
            end
        end

        // Dropping enable abandons whatever was in progress, without
        // recording it as a retry or a link drop
        if (!enable) begin
            state_d = ST_IDLE;
            retry_d = retry_q;
            drop_d  = drop_q;
            stab_d  = '0;
        end
    end

    // Per-state timer restarts on every state change and holds at its last value
    always_comb begin
        tmr_d = tmr_q;
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (tmr_q != TMO_LAST) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge apb3clk or negedge apb3presetn) begin
        if (!apb3presetn) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            stab_q        <= '0;
            retry_q       <= '0;
            drop_q        <= '0;
            gt_reset_q    <= 1'b0;
            link_stable_q <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            stab_q        <= stab_d;
            retry_q       <= retry_d;
            drop_q        <= drop_d;
            gt_reset_q    <= (state_d == ST_RESET);
            link_stable_q <= (state_d == ST_UP);
            fail_q        <= (state_d == ST_FAIL);
        end
    end

    assign gt_reset    = gt_reset_q;
    assign link_stable = link_stable_q;
    assign fail        = fail_q;
    assign state       = state_q;
    assign tx_freq_cnt = tx_cnt;
    assign rx_freq_cnt = rx_cnt;
    assign retry_cnt   = retry_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_gt_link_bringup_ctrl.sv
// Directed bench for the GT bring-up controller with a simple wrapper model:
// lock 400 cycles (2 us) after gt_reset falls, reset-done 200 cycles later.
`timescale 1ns/1ps
module tb_gt_link_bringup_ctrl;

    localparam int STAB = 64;
    localparam int TMO  = 1000;

    logic clk     = 1'b0;
    logic presetn = 1'b1;
    logic enable  = 1'b0;
    logic link    = 1'b1;
    logic pll_ok  = 1'b1;
    logic tx_div  = 1'b0;
    logic rx_div  = 1'b0;
    real  tx_half_ns = 49.64849;   // 10.0708 MHz
    real  rx_half_ns = 49.64849;

    logic seen_rst  = 1'b0;
    int   since_rst = 0;
    int   rst_pulses = 0;
    logic lock, txd, rxd;

    logic        gt_reset, link_stable, fail;
    logic [3:0]  state;
    logic [11:0] tx_freq_cnt, rx_freq_cnt;
    logic [1:0]  retry_cnt;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_bad    = 0;

    gt_link_bringup_ctrl #(
        .TIMEOUT_CYC (TMO),
        .STABLE_CYC  (STAB)
    ) dut (
        .apb3clk        (clk),
        .apb3presetn    (presetn),
        .enable         (enable),
        .lcpll_lock     (lock),
        .tx_resetdone   (txd),
        .rx_resetdone   (rxd),
        .link_status    (link),
        .txusrclk_div16 (tx_div),
        .rxusrclk_div16 (rx_div),
        .gt_reset       (gt_reset),
        .link_stable    (link_stable),
        .fail           (fail),
        .state          (state),
        .tx_freq_cnt    (tx_freq_cnt),
        .rx_freq_cnt    (rx_freq_cnt),
        .retry_cnt      (retry_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #2.5 clk = ~clk;
    always begin #(tx_half_ns); tx_div = ~tx_div; end
    always begin #(rx_half_ns); rx_div = ~rx_div; end

    // Wrapper model: status comes back a fixed time after the reset pulse
    always @(posedge clk) begin
        if (gt_reset) begin
            seen_rst  <= 1'b1;
            since_rst <= 0;
        end else if (since_rst < 100000) begin
            since_rst <= since_rst + 1;
        end
    end
    assign lock = pll_ok && seen_rst && (since_rst >= 400);
    assign txd  = lock && (since_rst >= 600);
    assign rxd  = lock && (since_rst >= 600);

    always @(posedge gt_reset) rst_pulses <= rst_pulses + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input string tag, input int st, input int max_cyc);
        int n = 0;
        while (int'(state) != st && n < max_cyc) begin
            step(1);
            n++;
        end
        check_val(tag, int'(state), st);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_state"}, int'(state), 0);
        check_val({tag, "_gt_reset"}, int'(gt_reset), 0);
        check_val({tag, "_link_stable"}, int'(link_stable), 0);
        check_val({tag, "_fail"}, int'(fail), 0);
        check_val({tag, "_tx_freq"}, int'(tx_freq_cnt), 0);
        check_val({tag, "_rx_freq"}, int'(rx_freq_cnt), 0);
        check_val({tag, "_retry"}, int'(retry_cnt), 0);
        check_val({tag, "_drop"}, int'(drop_cnt), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        // Reset values
        #3 presetn = 1'b0;
        step(2);
        check_all_zero("reset");
        @(negedge clk) presetn = 1'b1;
        step(2);
        check_val("idle_hold", int'(state), 0);

        // Nominal bring-up: 12-cycle reset pulse, 206.25 edges per window
        enable = 1'b1;
        step(1);
        check_val("gt_reset_rise", int'(gt_reset), 1);
        check_val("state_reset", int'(state), 1);
        n = 0;
        while (gt_reset && n < 100) begin
            n++;
            step(1);
        end
        check_val("gt_reset_width", n, 12);
        wait_state("reach_up", 7, 8000);
        check_val($sformatf("tx_freq=%0d_in_206_207", tx_freq_cnt),
                  int'(tx_freq_cnt >= 206 && tx_freq_cnt <= 207), 1);
        check_val($sformatf("rx_freq=%0d_in_206_207", rx_freq_cnt),
                  int'(rx_freq_cnt >= 206 && rx_freq_cnt <= 207), 1);
        check_val("up_retry", int'(retry_cnt), 0);
        check_val("up_link_stable", int'(link_stable), 1);
        check_val("up_fail", int'(fail), 0);

        // Three short link drops: requalify without a new reset
        base = rst_pulses;
        for (int i = 0; i < 3; i++) begin
            link = 1'b0;
            step(10);
            check_val($sformatf("drop%0d_qual", i), int'(state), 6);
            check_val($sformatf("drop%0d_stable_low", i), int'(link_stable), 0);
            link = 1'b1;
            n = 0;
            while (!link_stable && n < 500) begin
                step(1);
                n++;
            end
            check_val($sformatf("drop%0d_requal_lat=%0d_in_%0d_%0d", i, n, STAB + 2, STAB + 3),
                      int'(n >= STAB + 2 && n <= STAB + 3), 1);
            check_val($sformatf("drop%0d_cnt", i), int'(drop_cnt), i + 1);
        end
        check_val("drops_no_gt_reset", rst_pulses - base, 0);

        // Lock and link lost together: retry wins, drop still counted
        pll_ok = 1'b0;
        link   = 1'b0;
        wait_state("lock_link_loss_reset", 1, 10);
        check_val("lock_link_loss_drop", int'(drop_cnt), 4);
        check_val("lock_link_loss_retry", int'(retry_cnt), 1);
        pll_ok = 1'b1;
        link   = 1'b1;
        wait_state("reup_after_lock_loss", 7, 8000);
        check_val("reup_retry", int'(retry_cnt), 1);

        // Enable low leaves UP; slow RX clock (194.56 edges) forces a retry
        enable = 1'b0;
        step(1);
        check_val("disable_idle", int'(state), 0);
        check_val("disable_stable_low", int'(link_stable), 0);
        rx_half_ns = 52.63158;     // 9.5 MHz
        enable = 1'b1;
        wait_state("rx_slow_meas", 5, 2000);
        wait_state("rx_slow_retry_reset", 1, 4200);
        check_val($sformatf("rx_slow_freq=%0d_in_194_195", rx_freq_cnt),
                  int'(rx_freq_cnt >= 194 && rx_freq_cnt <= 195), 1);
        check_val($sformatf("rx_slow_tx_freq=%0d_in_206_207", tx_freq_cnt),
                  int'(tx_freq_cnt >= 206 && tx_freq_cnt <= 207), 1);
        check_val("rx_slow_retry", int'(retry_cnt), 1);

        // Asynchronous reset in the middle of a measurement window
        rx_half_ns = 49.64849;
        wait_state("meas_again", 5, 2000);
        step(100);
        @(negedge clk) presetn = 1'b0;
        #1;
        check_all_zero("async_meas");
        @(negedge clk) presetn = 1'b1;
        #1;
        check_val("restart_idle", int'(state), 0);
        step(1);
        check_val("restart_reset", int'(state), 1);
        check_val("restart_gt_reset", int'(gt_reset), 1);
        step(3);
        @(negedge clk) presetn = 1'b0;
        #1;
        check_val("async_gt_reset_drop", int'(gt_reset), 0);
        check_val("async_reset_state", int'(state), 0);
        @(negedge clk) presetn = 1'b1;
        step(1);

        // PLL never locks: four reset pulses then FAIL
        enable = 1'b0;
        step(2);
        pll_ok = 1'b0;
        base   = rst_pulses;
        enable = 1'b1;
        wait_state("no_lock_fail", 8, 6000);
        check_val("no_lock_pulses", rst_pulses - base, 4);
        check_val("no_lock_retry", int'(retry_cnt), 3);
        check_val("no_lock_fail_flag", int'(fail), 1);
        check_val("no_lock_stable", int'(link_stable), 0);
        step(5);
        check_val("fail_held", int'(state), 8);
        enable = 1'b0;
        step(1);
        check_val("fail_exit_idle", int'(state), 0);
        check_val("fail_exit_flag", int'(fail), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
